// File: rtl/gobou_wback.sv
// -----------------------------------------------------------------------------
// gobou_wback -- layer result write-back
//
// Buffers a stream of signed result words in a small FIFO and writes them to
// the image memory at consecutive addresses starting from a base address.
// Words are written only in cycles where the memory port is granted. The block
// counts accepted words and compares the count with the expected total when
// the stream drains.
//
// Ports
//   clk            sole clock, rising edge
//   xrst           synchronous active-high reset
//   in_begin       pulse: start (or restart) of a layer's result stream
//   in_valid       in_data carries a result word this cycle
//   in_end         pulse: stream finished (may coincide with last in_valid)
//   in_data        signed result word
//   output_addr    base address, sampled on in_begin
//   total_out      expected word count, sampled on in_begin
//   mem_gnt        image-memory port free this cycle
//   mem_img_we     write strobe (high only on a FIFO pop)
//   mem_img_addr   write address = base + words written so far
//   write_mem_img  write data = FIFO head
//   busy           high whenever not IDLE
//   done           one-cycle completion pulse
//   err            sticky: bit0 FIFO overflow, bit1 count mismatch
//
// State table
//   state | meaning
//   IDLE  | waiting for in_begin; in_valid/in_end ignored
//   RECV  | accepting words into the FIFO, writing when granted
//   DRAIN | stream ended, emptying the FIFO
//   DONE  | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module gobou_wback #(
    parameter int DWIDTH  = 16,
    parameter int IMGSIZE = 12,
    parameter int LWIDTH  = 10,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               in_begin,
    input  logic               in_valid,
    input  logic               in_end,
    input  logic [DWIDTH-1:0]  in_data,
    input  logic [IMGSIZE-1:0] output_addr,
    input  logic [LWIDTH-1:0]  total_out,
    input  logic               mem_gnt,
    output logic               mem_img_we,
    output logic [IMGSIZE-1:0] mem_img_addr,
    output logic [DWIDTH-1:0]  write_mem_img,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [DWIDTH-1:0]  fifo [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr, occ;
    logic [IMGSIZE-1:0] base, wcount;
    logic [LWIDTH-1:0]  total;
    logic [LWIDTH:0]    acnt;
    logic [1:0]         err_r;

    logic active, restart, empty, full;
    logic push_try, push, pop, ovf, last_pop, mismatch;

    assign active  = (state == RECV) || (state == DRAIN);
    assign restart = active && in_begin;

    // Pointers carry one extra wrap bit: equal -> empty, only wrap bit
    // differs -> full.
    assign occ   = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A restart discards the queue, so nothing of the old stream is written
    // in the restart cycle; reset likewise suppresses any write.
    assign pop      = active && !restart && !empty && mem_gnt && !xrst;
    assign push_try = (state == RECV) && !in_begin && in_valid;
    // When full, a same-cycle pop frees the slot the push needs.
    assign push     = push_try && (!full || pop);
    assign ovf      = push_try && full && !pop;
    assign last_pop = pop && (occ == {{AW{1'b0}}, 1'b1});
    assign mismatch = (acnt != {1'b0, total});

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_begin) state_nx = RECV;
            end
            RECV: begin
                if (in_begin)    state_nx = RECV;
                else if (in_end) state_nx = DRAIN;
            end
            DRAIN: begin
                if (in_begin)                state_nx = RECV;
                else if (empty || last_pop)  state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            wcount <= '0;
            acnt   <= '0;
            err_r  <= '0;
            base   <= '0;
            total  <= '0;
        end else begin
            state <= state_nx;
            if (in_begin && ((state == IDLE) || active)) begin
                base   <= output_addr;
                total  <= total_out;
                wr_ptr <= '0;
                rd_ptr <= '0;
                wcount <= '0;
                acnt   <= '0;
                err_r  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    // Saturate so a runaway stream still reads as a mismatch.
                    if (acnt != '1) acnt <= acnt + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    wcount <= wcount + 1'b1;
                end
                if (ovf) err_r[0] <= 1'b1;
                if ((state == DRAIN) && (state_nx == DONE) && mismatch)
                    err_r[1] <= 1'b1;
            end
        end
    end

    // Storage array has no reset; occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (push && !xrst) fifo[wr_ptr[AW-1:0]] <= in_data;
    end

    assign mem_img_we    = pop;
    assign mem_img_addr  = base + wcount;
    assign write_mem_img = fifo[rd_ptr[AW-1:0]];
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign err           = err_r;

endmodule

// File: doc/gobou_wback.md
GOBOU_WBACK -- requirements
Module: gobou_wback

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, meaning signed data word width.
REQ-002 SHALL have parameter IMGSIZE, default 12, meaning image-memory address width.
REQ-003 SHALL have parameter LWIDTH, default 10, meaning output-count width.
REQ-004 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port xrst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_begin  input  1  one-cycle pulse; start of one layer's result stream.
REQ-008 SHALL have port in_valid  input  1  in_data carries one result this cycle.
REQ-009 SHALL have port in_end  input  1  one-cycle pulse; stream finished (may coincide with the last in_valid).
REQ-010 SHALL have port in_data  input  DWIDTH  signed result word.
REQ-011 SHALL have port output_addr  input  IMGSIZE  base address; sampled on in_begin.
REQ-012 SHALL have port total_out  input  LWIDTH  expected word count; sampled on in_begin.
REQ-013 SHALL have port mem_gnt  input  1  image-memory port free this cycle.
REQ-014 SHALL have port mem_img_we  output  1  write strobe.
REQ-015 SHALL have port mem_img_addr  output  IMGSIZE  write address.
REQ-016 SHALL have port write_mem_img  output  DWIDTH  write data.
REQ-017 SHALL have port busy  output  1  high in any state except IDLE.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.
REQ-019 SHALL have port err  output  2  sticky flags: bit0 overflow, bit1 count mismatch.

Function
REQ-020 SHALL implement FSM states IDLE, RECV, DRAIN, DONE.
REQ-021 SHALL go IDLE->RECV on in_begin, latching base address and total_out, clearing FIFO, write count and err.
REQ-022 SHALL ignore in_valid/in_end while in IDLE (no push, no flag).
REQ-023 SHALL push in_data into FIFO on every in_valid in RECV.
REQ-024 SHALL pop the FIFO head when FIFO non-empty and mem_gnt=1, in RECV or DRAIN.
REQ-025 SHALL, on a pop cycle, drive mem_img_we=1 combinationally with write_mem_img=head, mem_img_addr=base+wcount (modulo 2^IMGSIZE), then increment wcount.
REQ-026 SHALL keep mem_img_we=0 in all non-pop cycles, with addr/data don't-care.
REQ-027 SHALL allow push and pop in the same cycle when full: net occupancy unchanged, no overflow.
REQ-028 SHALL, on push while full without a pop, drop the word and set err[0].
REQ-029 SHALL move RECV->DRAIN on in_end, pushing any same-cycle in_valid word first.
REQ-030 SHALL move DRAIN->DONE when the FIFO is empty (including the cycle of its last pop).
REQ-031 SHALL set err[1] on DRAIN->DONE if words accepted into FIFO != latched total_out.
REQ-032 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-033 SHALL treat in_begin seen in RECV/DRAIN as a restart: discard FIFO, relatch, stay/enter RECV, no done.
REQ-034 SHALL give one-cycle minimum latency from in_valid to mem_img_we (registered FIFO, no bypass).
REQ-035 SHALL use wrapping DEPTH-indexed pointers with an extra bit to distinguish full from empty.
REQ-036 SHALL treat total_out=0 as valid: stream with in_begin then in_end only gives done, err=0.

Reset
REQ-037 SHALL, while xrst=1 on a clock edge, force state IDLE, FIFO empty, wcount 0, err 0, mem_img_we 0, busy 0, done 0.
REQ-038 SHALL give reset priority over every other input, aborting any in-flight stream without further writes.

Verification
REQ-039 SHALL cover: base=0x100, total_out=3, 3 valids, mem_gnt=1 -> writes at 0x100,0x101,0x102 in order, done one cycle after last write, err=0.
REQ-040 SHALL cover: mem_gnt=0 while 4 words arrive, then 1 -> no write while stalled, 4 writes in order, err=0; fifth word while stalled -> err[0]=1.
REQ-041 SHALL cover: total_out=5, only 4 valids then in_end -> 4 writes, done pulse, err=2'b10.
REQ-042 SHALL cover: base=0xFFE, total_out=3 -> addresses 0xFFE,0xFFF,0x000.
REQ-043 SHALL cover: xrst asserted during RECV with 2 words queued -> next cycle busy=0, no writes, no done, err=0.
REQ-044 SHALL cover: in_end coincident with last in_valid, and in_begin during DRAIN -> last word written; restart discards queue, no done for aborted stream.
